sha256_padder: RTL and testbench
================================

// Module: sha256_padder
// PURPOSE
//  Upstream feeder for the SHA-256 core controller. Accepts a byte stream, applies SHA-256 padding
//  (0x80, zero bytes, 64-bit big-endian bit length) and delivers 512-bit blocks to the core.
//  Each block is delivered as 64 contiguous bytes after one strobe cycle.
//  Buffers one whole block, so the core never sees a gap inside a block.
// PARAMETERS
//  LEN_W   64   width of the message bit-length counter; the length field is zero-extended to 64 bits
//  BLK_B   64   bytes per block (fixed by SHA-256; not to be overridden)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-high reset
//  in_data      in   8   message byte
//  in_valid     in   1   in_data valid
//  in_last      in   1   in_data is the final message byte (qualified by in_valid)
//  in_msg_empty in   1   with in_valid & in_last: zero-length message, in_data ignored
//  in_ready     out  1   padder accepts a byte this cycle
//  core_busy    in   1   busy flag from the core controller
//  out_data     out  8   block byte to the core
//  out_valid    out  1   out_data valid (64 consecutive cycles per block)
//  first_block  out  1   1-cycle strobe, lead cycle of a message's first block
//  last_block   out  1   1-cycle strobe, lead cycle of a message's last block
//  len_ovf      out  1   sticky; message exceeded 2^LEN_W-1 bits
// BEHAVIOUR
//  Reset values: all outputs 0; buffer contents don't-care; wr_ptr=rd_ptr=0; bitlen=0; state=IDLE.
//  Transfer: a byte moves when in_valid & in_ready; bitlen += 8 per byte; len_ovf sets on carry-out.
//  States:
//   IDLE: in_ready=1. First accepted byte is written to buf[0] and the state goes to FILL.
//         With in_last: go to PAD. With in_msg_empty: write nothing and go to PAD.
//   FILL: in_ready=1. Write buf[wr_ptr++].
//         in_last -> PAD.
//         wr_ptr wraps 63->0 -> WAIT (block full, message continues).
//   PAD:  in_ready=0. Writes one byte per cycle:
//         0x80 once, then 0x00 until wr_ptr==56, then bitlen bytes 7..0, MSB first.
//         If 0x80 or zero fill reaches wr_ptr==63 -> 0 before the length is written, the block
//         is full and not last: go to WAIT; padding resumes at buf[0] after EMIT.
//         Length byte at wr_ptr==63 -> block marked last, go to WAIT.
//   WAIT: in_ready=0. For the first block of a message, hold until core_busy==0.
//         Subsequent blocks of the same message proceed immediately. Go to LEAD.
//   LEAD: one cycle. first_block=1 if block index==0; last_block=1 if block marked last.
//         Both strobes assert together for single-block messages. Go to EMIT.
//   EMIT: out_valid=1 and out_data=buf[rd_ptr++] for exactly 64 cycles, registered, from the cycle
//         after LEAD. After byte 63: last block -> IDLE, clear bitlen and block index;
//         padding pending -> PAD; otherwise -> FILL.
//  in_ready is 0 in PAD/WAIT/LEAD/EMIT. Input stalls (in_valid=0) in FILL are allowed indefinitely.
//  Width rules: wr_ptr/rd_ptr are 6-bit and wrap naturally. The length field is bitlen mod 2^64.
//  Boundaries:
//   55-byte message: 1 block. 56..63 bytes: 2 blocks. 64 bytes: 2 blocks, 2nd begins 0x80.
//   in_last on the byte that fills wr_ptr 63: next block begins with 0x80.
//   in_valid during a not-ready state is ignored; the source must hold it.
//   core_busy rising during EMIT is ignored; the block finishes.
//   reset mid-EMIT: out_valid=0 and strobes=0 from the next cycle; partial block discarded.
// STRUCTURE
//  Shared package (sha256_pkg): SHA256_BLK_BYTES=64, SHA256_LEN_POS=56, SHA256_PAD_BYTE=8'h80,
//  padder state encoding.
//  One sub-module: sha256_blk_buf, a 64x8 single-port-write / registered-read block buffer.
//  FSM, pointers and bitlen live in the top level.
// TESTING
//  "abc" (61 62 63, last) -> 1 block: 61 62 63 80, 52x00, 00x7, 18. first_block and last_block
//   both high in the same LEAD cycle.
//  Empty message (in_msg_empty) -> 1 block: 80, 62x00, 00. Both strobes set.
//  56 bytes 0x00..0x37 -> block1: data, 80, 7x00 (last_block=0). block2: 56x00, 00x6, 01 C0
//   (last_block=1, first_block=0).
//  64 bytes -> block1 = data only. block2 = 80, 55x00, 00x6, 02 00.
//   Exactly 2 LEAD cycles, 128 out_valid cycles.
//  core_busy=1 held 20 cycles at WAIT -> no LEAD and out_valid=0 until core_busy falls.
//   LEAD follows 1 cycle later.
//  reset asserted at EMIT byte 10 -> next cycle out_valid=0, in_ready=1.
//   A new "abc" then produces a correct digest input.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared constants, padder state encoding and a length-field byte selector
// for the SHA-256 input padder.
package sha256_pkg;

    localparam int         SHA256_BLK_BYTES = 64;
    localparam int         SHA256_LEN_POS   = 56;
    localparam logic [7:0] SHA256_PAD_BYTE  = 8'h80;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_PAD  = 3'd2,
        ST_WAIT = 3'd3,
        ST_LEAD = 3'd4,
        ST_EMIT = 3'd5
    } pad_state_t;

    // pos is the offset from SHA256_LEN_POS; offset 0 carries the MSB byte.
    function automatic logic [7:0] len_byte(input logic [63:0] len, input logic [2:0] pos);
        return len[{~pos, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/sha256_blk_buf.sv
// One-block byte buffer: single write port, registered read port.
// The read register is cleared by reset so the padder's out_data starts at zero.
module sha256_blk_buf
    import sha256_pkg::*;
#(
    parameter int DEPTH = SHA256_BLK_BYTES,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [7:0]    i_wr_data,
    input  logic [AW-1:0] i_rd_addr,
    output logic [7:0]    o_rd_data
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_data <= 8'h00;
        end else begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/sha256_padder.sv
// SHA-256 message padder: buffers one 64-byte block, appends 0x80, zero fill and the
// 64-bit big-endian bit length, then streams each block after a one-cycle strobe.
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64,
    parameter int BLK_B = SHA256_BLK_BYTES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    input  logic       in_msg_empty,
    output logic       in_ready,
    input  logic       core_busy,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       first_block,
    output logic       last_block,
    output logic       len_ovf
);

    pad_state_t       r_state;
    logic [5:0]       r_wr_ptr;
    logic [5:0]       r_rd_ptr;
    logic [LEN_W-1:0] r_bitlen;
    logic             r_len_ovf;
    logic             r_out_valid;
    logic             r_first_block;
    logic             r_last_block;
    logic             r_pad_80_done;
    logic             r_len_ok;
    logic             r_pad_pend;
    logic             r_blk_last;
    logic             r_blk_idx_nz;

    logic             w_state_ready;
    logic             w_accept;
    logic             w_empty_msg;
    logic             w_len_slot;
    logic             w_bitlen_carry;
    logic [LEN_W-1:0] w_bitlen_nx;
    logic [63:0]      w_len64;
    logic [7:0]       w_pad_byte;
    logic             w_wr_en;
    logic [7:0]       w_wr_data;
    logic [7:0]       w_rd_data;

    // Input handshake: a byte transfers on any cycle where in_valid and in_ready are both
    // high; the source must hold in_valid/in_data/in_last stable until that cycle.
    assign w_state_ready = (r_state == ST_IDLE) || (r_state == ST_FILL);
    assign in_ready      = w_state_ready && !reset;
    assign w_accept      = in_valid && in_ready;
    assign w_empty_msg   = (r_state == ST_IDLE) && in_last && in_msg_empty;

    assign {w_bitlen_carry, w_bitlen_nx} = {1'b0, r_bitlen} + (LEN_W + 1)'(8);

    generate
        if (LEN_W >= 64) begin : g_len_trunc
            assign w_len64 = r_bitlen[63:0];
        end else begin : g_len_ext
            assign w_len64 = {{(64 - LEN_W){1'b0}}, r_bitlen};
        end
    endgenerate

    // Length bytes only go into a block whose 0x80 landed early enough to leave room for them.
    assign w_len_slot = r_pad_80_done && r_len_ok && (r_wr_ptr >= 6'(SHA256_LEN_POS));

    always_comb begin
        w_pad_byte = 8'h00;
        if (!r_pad_80_done) begin
            w_pad_byte = SHA256_PAD_BYTE;
        end else if (w_len_slot) begin
            w_pad_byte = len_byte(w_len64, r_wr_ptr[2:0]);
        end
    end

    assign w_wr_en   = (w_accept && !w_empty_msg) || (r_state == ST_PAD);
    assign w_wr_data = (r_state == ST_PAD) ? w_pad_byte : in_data;

    sha256_blk_buf #(
        .DEPTH(BLK_B)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .i_wr_en  (w_wr_en),
        .i_wr_addr(r_wr_ptr),
        .i_wr_data(w_wr_data),
        .i_rd_addr(r_rd_ptr),
        .o_rd_data(w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_wr_ptr      <= 6'd0;
            r_rd_ptr      <= 6'd0;
            r_bitlen      <= '0;
            r_len_ovf     <= 1'b0;
            r_out_valid   <= 1'b0;
            r_first_block <= 1'b0;
            r_last_block  <= 1'b0;
            r_pad_80_done <= 1'b0;
            r_len_ok      <= 1'b0;
            r_pad_pend    <= 1'b0;
            r_blk_last    <= 1'b0;
            r_blk_idx_nz  <= 1'b0;
        end else begin
            r_first_block <= 1'b0;
            r_last_block  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_pad_80_done <= 1'b0;
                        r_len_ok      <= 1'b0;
                        if (w_empty_msg) begin
                            r_state <= ST_PAD;
                        end else begin
                            r_wr_ptr  <= r_wr_ptr + 6'd1;
                            r_bitlen  <= w_bitlen_nx;
                            r_len_ovf <= r_len_ovf | w_bitlen_carry;
                            r_state   <= in_last ? ST_PAD : ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (w_accept) begin
                        r_wr_ptr  <= r_wr_ptr + 6'd1;
                        r_bitlen  <= w_bitlen_nx;
                        r_len_ovf <= r_len_ovf | w_bitlen_carry;
                        if (in_last) begin
                            r_pad_80_done <= 1'b0;
                            r_len_ok      <= 1'b0;
                        end
                        // A final byte that fills the block defers all padding to the next block.
                        if (r_wr_ptr == 6'd63) begin
                            r_blk_last <= 1'b0;
                            r_pad_pend <= in_last;
                            r_state    <= ST_WAIT;
                        end else if (in_last) begin
                            r_state <= ST_PAD;
                        end
                    end
                end
                ST_PAD: begin
                    r_wr_ptr <= r_wr_ptr + 6'd1;
                    if (!r_pad_80_done) begin
                        r_pad_80_done <= 1'b1;
                        if (r_wr_ptr < 6'(SHA256_LEN_POS)) begin
                            r_len_ok <= 1'b1;
                        end
                    end
                    if (r_wr_ptr == 6'd63) begin
                        r_state <= ST_WAIT;
                        if (w_len_slot) begin
                            r_blk_last <= 1'b1;
                            r_pad_pend <= 1'b0;
                        end else begin
                            r_blk_last <= 1'b0;
                            r_pad_pend <= 1'b1;
                            r_len_ok   <= 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_blk_idx_nz || !core_busy) begin
                        r_state       <= ST_LEAD;
                        r_first_block <= !r_blk_idx_nz;
                        r_last_block  <= r_blk_last;
                    end
                end
                ST_LEAD: begin
                    r_rd_ptr    <= r_rd_ptr + 6'd1;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_EMIT;
                end
                ST_EMIT: begin
                    // Reads run one address ahead of out_data, so rd_ptr back at 0 means byte 63 is out.
                    if (r_rd_ptr == 6'd0) begin
                        r_out_valid <= 1'b0;
                        if (r_blk_last) begin
                            r_state      <= ST_IDLE;
                            r_bitlen     <= '0;
                            r_blk_idx_nz <= 1'b0;
                            r_blk_last   <= 1'b0;
                        end else begin
                            r_blk_idx_nz <= 1'b1;
                            r_pad_pend   <= 1'b0;
                            r_state      <= r_pad_pend ? ST_PAD : ST_FILL;
                        end
                    end else begin
                        r_rd_ptr <= r_rd_ptr + 6'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign out_data    = w_rd_data;
    assign out_valid   = r_out_valid;
    assign first_block = r_first_block;
    assign last_block  = r_last_block;
    assign len_ovf     = r_len_ovf;

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: known messages, boundary lengths, core_busy hold
// and mid-block reset, checked against a byte-level SHA-256 padding model.
module tb_sha256_padder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_msg_empty;
  logic       in_ready;
  logic       core_busy;
  logic [7:0] out_data;
  logic       out_valid;
  logic       first_block;
  logic       last_block;
  logic       len_ovf;

  int checks = 0;
  int errors = 0;

  logic [7:0] msg_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [1:0] strb_q[$];

  // clock / reset
  always #5 clk = ~clk;

  sha256_padder dut (
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_msg_empty(in_msg_empty),
    .in_ready    (in_ready),
    .core_busy   (core_busy),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .first_block (first_block),
    .last_block  (last_block),
    .len_ovf     (len_ovf)
  );

  // output capture
  always @(negedge clk) begin
    if (out_valid) got_q.push_back(out_data);
    if (first_block || last_block) strb_q.push_back({first_block, last_block});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference padding: message, 0x80, zeros to 56 mod 64, 64-bit big-endian bit length
  task automatic build_exp();
    logic [63:0] bl;
    bl = 64'(msg_q.size()) * 64'd8;
    exp_q.delete();
    foreach (msg_q[i]) exp_q.push_back(msg_q[i]);
    exp_q.push_back(8'h80);
    while ((exp_q.size() % 64) != 56) exp_q.push_back(8'h00);
    for (int k = 7; k >= 0; k--) exp_q.push_back(bl[8*k +: 8]);
  endtask

  task automatic load_seq(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'(i));
  endtask

  task automatic load_abc();
    msg_q.delete();
    msg_q.push_back(8'h61);
    msg_q.push_back(8'h62);
    msg_q.push_back(8'h63);
  endtask

  // driver: entered and left on a falling edge
  task automatic send_byte(input logic [7:0] d, input logic lst, input logic emp);
    int guard;
    guard = 0;
    in_data = d; in_valid = 1'b1; in_last = lst; in_msg_empty = emp;
    while (in_ready !== 1'b1 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("in_ready_wait", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; in_msg_empty = 1'b0;
  endtask

  task automatic send_msg(input bit gaps);
    if (msg_q.size() == 0) begin
      send_byte(8'hA5, 1'b1, 1'b1);
    end else begin
      for (int i = 0; i < msg_q.size(); i++) begin
        send_byte(msg_q[i], (i == msg_q.size() - 1), 1'b0);
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
  endtask

  task automatic wait_out(input int n, input string tag);
    int guard;
    guard = 0;
    while (got_q.size() < n && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    repeat (4) @(negedge clk);
    chk({tag, "_nbytes"}, got_q.size(), n);
  endtask

  task automatic check_stream(input string tag);
    int bad;
    int bi;
    bad = -1;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
    bi = (bad < 0) ? 0 : bad;
    chk($sformatf("%s_byte%0d", tag, bi), got_q[bi], exp_q[bi]);
    chk({tag, "_ready_after"}, in_ready, 1);
  endtask

  task automatic clear_caps();
    got_q.delete();
    strb_q.delete();
  endtask

  task automatic run_msg(input string tag, input bit gaps);
    clear_caps();
    build_exp();
    send_msg(gaps);
    wait_out(exp_q.size(), tag);
    check_stream(tag);
  endtask

  initial begin
    int guard;
    reset = 1'b1; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0;
    in_msg_empty = 1'b0; core_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_first", first_block, 0);
    chk("rst_last", last_block, 0);
    chk("rst_len_ovf", len_ovf, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_data", out_data, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);

    // "abc": one block, both strobes together
    load_abc();
    run_msg("abc", 1'b0);
    chk("abc_b0", got_q[0], 8'h61);
    chk("abc_b3", got_q[3], 8'h80);
    chk("abc_b62", got_q[62], 8'h00);
    chk("abc_b63", got_q[63], 8'h18);
    chk("abc_nstrobe", strb_q.size(), 1);
    chk("abc_strobe", strb_q[0], 2'b11);

    // empty message
    msg_q.delete();
    run_msg("empty", 1'b0);
    chk("empty_b0", got_q[0], 8'h80);
    chk("empty_b63", got_q[63], 8'h00);
    chk("empty_strobe", strb_q[0], 2'b11);

    // 56 bytes: length spills into a second block
    load_seq(56);
    run_msg("m56", 1'b1);
    chk("m56_b55", got_q[55], 8'h37);
    chk("m56_b56", got_q[56], 8'h80);
    chk("m56_b126", got_q[126], 8'h01);
    chk("m56_b127", got_q[127], 8'hC0);
    chk("m56_nstrobe", strb_q.size(), 2);
    chk("m56_strobe0", strb_q[0], 2'b10);
    chk("m56_strobe1", strb_q[1], 2'b01);

    // 64 bytes: second block starts with 0x80; core_busy raised mid-emit is ignored
    load_seq(64);
    clear_caps();
    build_exp();
    send_msg(1'b0);
    guard = 0;
    while (got_q.size() < 10 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    core_busy = 1'b1;
    wait_out(128, "m64");
    core_busy = 1'b0;
    check_stream("m64");
    chk("m64_b63", got_q[63], 8'h3F);
    chk("m64_b64", got_q[64], 8'h80);
    chk("m64_b126", got_q[126], 8'h02);
    chk("m64_b127", got_q[127], 8'h00);
    chk("m64_nstrobe", strb_q.size(), 2);
    chk("m64_strobe0", strb_q[0], 2'b10);
    chk("m64_strobe1", strb_q[1], 2'b01);

    // 55 bytes: exactly one block
    load_seq(55);
    run_msg("m55", 1'b1);
    chk("m55_b55", got_q[55], 8'h80);
    chk("m55_b63", got_q[63], 8'hB8);
    chk("m55_strobe", strb_q[0], 2'b11);

    // core_busy held: nothing leaves WAIT until it falls
    core_busy = 1'b1;
    load_abc();
    clear_caps();
    build_exp();
    send_msg(1'b0);
    repeat (100) @(negedge clk);
    chk("busy_no_out", got_q.size(), 0);
    chk("busy_no_strobe", strb_q.size(), 0);
    chk("busy_ready", in_ready, 0);
    core_busy = 1'b0;
    @(negedge clk);
    chk("busy_lead_first", first_block, 1);
    chk("busy_lead_last", last_block, 1);
    chk("busy_lead_valid", out_valid, 0);
    @(negedge clk);
    chk("busy_emit_valid", out_valid, 1);
    chk("busy_emit_b0", out_data, 8'h61);
    wait_out(64, "busy");
    check_stream("busy");

    // reset in the middle of a block
    load_abc();
    clear_caps();
    send_msg(1'b0);
    guard = 0;
    while (got_q.size() < 10 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("rstmid_reached", got_q.size() >= 10, 1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rstmid_valid", out_valid, 0);
    chk("rstmid_ready", in_ready, 1);
    chk("rstmid_first", first_block, 0);
    chk("rstmid_last", last_block, 0);
    @(negedge clk);
    clear_caps();
    repeat (80) @(negedge clk);
    chk("rstmid_quiet", got_q.size(), 0);
    load_abc();
    run_msg("rstmid_abc", 1'b0);
    chk("rstmid_abc_b63", got_q[63], 8'h18);
    chk("rstmid_abc_strobe", strb_q[0], 2'b11);

    chk("final_len_ovf", len_ovf, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
